// File: rtl/reg_univ_pkg.sv
// Shared definitions for the 4-bit universal register: operation codes,
// direction codes and the per-bit next-state select used by the bit slices.
package reg_univ_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SHIFT = 2'b00;
    localparam mode_t MODE_ROT   = 2'b01;
    localparam mode_t MODE_LOAD  = 2'b10;
    localparam mode_t MODE_HOLD  = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Per-bit next-state source. LO is the neighbour one position below
    // (feeds a left move), HI is the neighbour one position above (feeds a
    // right move).
    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_LO   = 2'b01,
        SEL_HI   = 2'b10,
        SEL_LOAD = 2'b11
    } sel_t;

    // Shift and rotate move bits the same way; they differ only in what
    // enters at the end of the register, which the top level resolves.
    function automatic sel_t next_sel(input mode_t m, input logic dir);
        sel_t s;
        s = SEL_HOLD;
        case (m)
            MODE_SHIFT,
            MODE_ROT:  s = (dir == DIR_LEFT) ? SEL_LO : SEL_HI;
            MODE_LOAD: s = SEL_LOAD;
            default:   s = SEL_HOLD;
        endcase
        return s;
    endfunction

    // True for every enabled operation that rewrites s_out (all but HOLD).
    function automatic logic sout_updates(input mode_t m);
        return (m != MODE_HOLD);
    endfunction

endpackage

// File: rtl/reg_cond_4b_bit_slice.sv
// One storage bit of the universal register: 4:1 next-state mux feeding an
// async-reset flop with enable.
module reg_bit_slice
    import reg_univ_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  sel_t sel,
    input  logic lo_in,
    input  logic hi_in,
    input  logic ld_in,
    output logic q
);

    logic nxt;

    // Pick the next value; unselected inputs never reach the flop.
    always_comb begin
        nxt = q;
        case (sel)
            SEL_HOLD: nxt = q;
            SEL_LO:   nxt = lo_in;
            SEL_HI:   nxt = hi_in;
            SEL_LOAD: nxt = ld_in;
            default:  nxt = q;
        endcase
    end

    // Storage bit; reset overrides any edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/reg_cond_4b.sv
// 4-bit universal register: hold, shift with serial in/out, rotate, parallel
// load. STRUCTURAL selects between a behavioural case-on-mode coding and a
// bit-slice coding; both are cycle-identical.
module reg_cond_4b
    import reg_univ_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit STRUCTURAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enb,
    input  logic             dir,
    input  logic             s_in,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             s_out
);

    logic [WIDTH-1:0] q_r;
    logic             so_r;

    assign q     = q_r;
    assign s_out = so_r;

    generate
        if (STRUCTURAL) begin : g_struct
            sel_t             sel;
            logic             is_rot;
            logic [WIDTH-1:0] lo_nb;
            logic [WIDTH-1:0] hi_nb;
            logic             so_en;
            logic             so_nxt;

            assign sel    = next_sel(mode, dir);
            assign is_rot = (mode == MODE_ROT);

            // Neighbour wiring. The end bits take s_in when shifting and the
            // bit from the opposite end when rotating.
            for (genvar i = 0; i < WIDTH; i++) begin : g_nb
                if (i == 0) begin : g_lo_end
                    assign lo_nb[i] = is_rot ? q_r[WIDTH-1] : s_in;
                end else begin : g_lo_mid
                    assign lo_nb[i] = q_r[i-1];
                end
                if (i == WIDTH-1) begin : g_hi_end
                    assign hi_nb[i] = is_rot ? q_r[0] : s_in;
                end else begin : g_hi_mid
                    assign hi_nb[i] = q_r[i+1];
                end

                reg_bit_slice u_slice (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .en    (enb),
                    .sel   (sel),
                    .lo_in (lo_nb[i]),
                    .hi_in (hi_nb[i]),
                    .ld_in (d[i]),
                    .q     (q_r[i])
                );
            end

            // s_out takes the ejected bit on a shift and clears on rotate/load.
            always_comb begin
                so_en  = enb & sout_updates(mode);
                so_nxt = 1'b0;
                if (mode == MODE_SHIFT) begin
                    so_nxt = (dir == DIR_LEFT) ? q_r[WIDTH-1] : q_r[0];
                end
            end

            // Serial-out flop, separate from the data slices.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    so_r <= 1'b0;
                end else if (so_en) begin
                    so_r <= so_nxt;
                end
            end
        end else begin : g_behav
            // Whole register updated from a single case on the operation.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_r  <= '0;
                    so_r <= 1'b0;
                end else if (enb) begin
                    case (mode)
                        MODE_SHIFT: begin
                            if (dir == DIR_LEFT) begin
                                q_r  <= {q_r[WIDTH-2:0], s_in};
                                so_r <= q_r[WIDTH-1];
                            end else begin
                                q_r  <= {s_in, q_r[WIDTH-1:1]};
                                so_r <= q_r[0];
                            end
                        end
                        MODE_ROT: begin
                            if (dir == DIR_LEFT) begin
                                q_r <= {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                            end else begin
                                q_r <= {q_r[0], q_r[WIDTH-1:1]};
                            end
                            so_r <= 1'b0;
                        end
                        MODE_LOAD: begin
                            q_r  <= d;
                            so_r <= 1'b0;
                        end
                        default: begin
                            q_r  <= q_r;
                            so_r <= so_r;
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_reg_cond_4b.sv
// Scoreboard bench: both codings of reg_cond_4b run side by side against an
// arithmetic reference model; a monitor pops expected values after each edge
// and after each asynchronous reset assertion.
module tb_reg_cond_4b;

    typedef struct {
        logic [3:0] q;
        logic       so;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enb = 1'b0;
    logic       dir = 1'b0;
    logic       s_in = 1'b0;
    logic [1:0] mode = 2'b11;
    logic [3:0] d = 4'h0;

    logic [3:0] q_b, q_s;
    logic       so_b, so_s;

    int checks = 0;
    int failures = 0;

    exp_t exp_q[$];
    event chk_ev;

    logic [3:0] m_q = 4'h0;
    logic       m_so = 1'b0;

    always #5 clk = ~clk;

    reg_cond_4b #(.WIDTH(4), .STRUCTURAL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .enb(enb), .dir(dir), .s_in(s_in),
        .mode(mode), .d(d), .q(q_b), .s_out(so_b)
    );

    reg_cond_4b #(.WIDTH(4), .STRUCTURAL(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .enb(enb), .dir(dir), .s_in(s_in),
        .mode(mode), .d(d), .q(q_s), .s_out(so_s)
    );

    task automatic check(input string name, input logic [3:0] aq, input logic aso,
                         input logic [3:0] eq, input logic eso);
        checks++;
        if (aq !== eq || aso !== eso) begin
            failures++;
            $display("FAIL %s: got q=%b s_out=%b, expected q=%b s_out=%b at %0t",
                     name, aq, aso, eq, eso, $time);
        end
    endtask

    // Reference model: register as a number, operations as arithmetic.
    task automatic model_edge(input logic r, input logic e, input logic dr,
                              input logic si, input logic [1:0] m, input logic [3:0] dd);
        int v;
        v = int'(m_q);
        if (!r) begin
            m_q = 4'h0; m_so = 1'b0;
        end else if (e) begin
            case (m)
                2'b00: begin
                    if (!dr) begin
                        m_so = (v >= 8);
                        m_q  = 4'((v * 2 + int'(si)) % 16);
                    end else begin
                        m_so = (v % 2 == 1);
                        m_q  = 4'(v / 2 + 8 * int'(si));
                    end
                end
                2'b01: begin
                    if (!dr) m_q = 4'((v * 2) % 16 + v / 8);
                    else     m_q = 4'(v / 2 + 8 * (v % 2));
                    m_so = 1'b0;
                end
                2'b10: begin
                    m_q = dd; m_so = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    // One clock cycle of stimulus. A falling rst_n is applied first so the
    // asynchronous clear is checked before the next rising edge.
    task automatic step(input logic r, input logic e, input logic dr, input logic si,
                        input logic [1:0] m, input logic [3:0] dd);
        exp_t x;
        @(negedge clk);
        if (!r && rst_n) begin
            rst_n = 1'b0;
            m_q = 4'h0; m_so = 1'b0;
            x.q = m_q; x.so = m_so;
            exp_q.push_back(x);
            ->chk_ev;
            #2;
        end
        rst_n = r; enb = e; dir = dr; s_in = si; mode = m; d = dd;
        model_edge(r, e, dr, si, m, dd);
        x.q = m_q; x.so = m_so;
        exp_q.push_back(x);
    endtask

    // Check against a literal value just after the upcoming edge.
    task automatic chk_edge(input string name, input logic [3:0] eq, input logic eso);
        @(posedge clk);
        #2;
        check(name, q_s, so_s, eq, eso);
    endtask

    // Monitor: one expected entry per rising edge and per reset assertion.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("sb_behav", q_b, so_b, x.q, x.so);
                check("sb_struct", q_s, so_s, x.q, x.so);
                check("equiv", q_s, so_s, q_b, so_b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic r, e, dr, si;
        logic [1:0] m;
        logic [3:0] dd;

        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'h0);
        check("reset_state", q_s, so_s, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'h0);

        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 4'b1011);
        chk_edge("load_1011", 4'b1011, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'h0);
        check("reset_async", q_s, so_s, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'h0);

        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 4'b1010);
        chk_edge("load_1010", 4'b1010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 4'b0101);
            chk_edge("enb0_hold", 4'b1010, 1'b0);
        end

        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 4'b1001);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 4'b0000);
        chk_edge("shl_1", 4'b0011, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b1111);
        chk_edge("shl_2", 4'b0110, 1'b0);

        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 4'b1001);
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'b1111);
        chk_edge("shr_1", 4'b0100, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 4'b1111);
        chk_edge("mode_hold", 4'b0100, 1'b1);

        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 4'b1000);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 4'h0);
        chk_edge("rotl_1", 4'b0001, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 4'h0);
        chk_edge("rotl_2", 4'b0010, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 4'h0);
        chk_edge("rotl_3", 4'b0100, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 4'h0);
        chk_edge("rotl_4", 4'b1000, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 4'h0);
        chk_edge("rotr_1", 4'b0100, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            r  = ($urandom_range(0, 31) != 0);
            e  = ($urandom_range(0, 3) != 0);
            dr = 1'($urandom_range(0, 1));
            si = 1'($urandom_range(0, 1));
            m  = 2'($urandom_range(0, 3));
            dd = 4'($urandom_range(0, 15));
            step(r, e, dr, si, m, dd);
        end

        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'h0);
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
